// File: rtl/chip_host_driver_pkg.sv
// Shared types and constants for the host-side accelerator driver.
//   state_e    : driver FSM states
//   cnt_t      : word counter type (CNT_WIDTH bits, must hold max of the NB_* counts)
//   *_DFLT     : default word width, per-layer word counts and output buffer depth
package chip_host_driver_pkg;

    localparam int unsigned MEM_BW_DFLT     = 128;
    localparam int unsigned NB_W_DFLT       = 2304;
    localparam int unsigned NB_A_DFLT       = 12544;
    localparam int unsigned NB_O_DFLT       = 12544;
    localparam int unsigned LOG2_OBUF_DFLT  = 4;
    localparam int unsigned CNT_WIDTH       = 16;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_RUN,
        ST_STREAM,
        ST_WAIT_IDLE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Chip output words are captured only from WAIT_RUN through DRAIN.
    function automatic logic in_capture(input state_e s);
        return (s == ST_WAIT_RUN) || (s == ST_STREAM) ||
               (s == ST_WAIT_IDLE) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/chip_host_driver_stream_skid_buffer.sv
// stream_skid_buffer: 2-entry valid/ready stage with registered output side.
//   clk, srst      : clock, synchronous active-high reset (flushes both entries)
//   in_data/valid  : upstream word; in_ready depends only on occupancy
//   out_data/valid : registered downstream word, held stable until out_ready
module stream_skid_buffer #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             in_fire;

    // A free slot exists whenever the skid entry is empty.
    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Refill the output register from skid first, then from the input.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        in_fire      = in_valid && !skid_valid_q;

        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/chip_host_driver.sv
// chip_host_driver: feeds one conv layer of weights/activations into the
// accelerator, pulses start, and captures every output word into a FIFO
// drained by the host sink.
//   clk, srst_in          : clock, synchronous active-high reset (aborts a layer)
//   cmd_go/busy/done      : layer command, activity flag, one-cycle completion pulse
//   err_overflow          : sticky, an output word was dropped on a full buffer
//   src_w_*, src_a_*      : host weight / activation streams (valid/ready)
//   weights_*, activations_*, start, running, out, output_valid : chip pins
//   snk_*                 : captured output words, first-word-fall-through
//   perf_cycles           : only with DRV_PERF_CNT_EN, running-cycle counter
module chip_host_driver
    import chip_host_driver_pkg::*;
#(
    parameter int unsigned MEM_BW     = MEM_BW_DFLT,
    parameter int unsigned NB_W_WORDS = NB_W_DFLT,
    parameter int unsigned NB_A_WORDS = NB_A_DFLT,
    parameter int unsigned NB_O_WORDS = NB_O_DFLT,
    parameter int unsigned LOG2_OBUF  = LOG2_OBUF_DFLT
) (
    input  logic              clk,
    input  logic              srst_in,
    input  logic              cmd_go,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    input  logic [MEM_BW-1:0] src_w_data,
    input  logic              src_w_valid,
    output logic              src_w_ready,
    input  logic [MEM_BW-1:0] src_a_data,
    input  logic              src_a_valid,
    output logic              src_a_ready,
    output logic [MEM_BW-1:0] weights_input,
    output logic              weights_valid,
    input  logic              weights_ready,
    output logic [MEM_BW-1:0] activations_input,
    output logic              activations_valid,
    input  logic              activations_ready,
    output logic              start,
    input  logic              running,
    input  logic [MEM_BW-1:0] out,
    input  logic              output_valid,
    output logic [MEM_BW-1:0] snk_data,
    output logic              snk_valid,
    input  logic              snk_ready
`ifdef DRV_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int unsigned PTR_W      = LOG2_OBUF;
    localparam int unsigned FILL_W     = LOG2_OBUF + 1;
    localparam int unsigned OBUF_DEPTH = 1 << LOG2_OBUF;

    state_e state_q, state_d;
    logic   busy_q, done_q, start_q, err_q, err_d;
    cnt_t   w_cnt_q, w_cnt_d, a_cnt_q, a_cnt_d, o_cnt_q, o_cnt_d;
    cnt_t   w_enq_q, w_enq_d, a_enq_q, a_enq_d;

    logic [MEM_BW-1:0] obuf_q [OBUF_DEPTH];
    logic [MEM_BW-1:0] obuf_d [OBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              snk_valid_q;

    logic go_accept, w_allow, a_allow, w_skid_rdy, a_skid_rdy;
    logic wr_req, push, pop, full;

    assign go_accept = (state_q == ST_IDLE) && cmd_go;

    // Host side only pulls while streaming and until the layer quota is enqueued.
    assign w_allow     = (state_q == ST_STREAM) && (w_enq_q != cnt_t'(NB_W_WORDS));
    assign a_allow     = (state_q == ST_STREAM) && (a_enq_q != cnt_t'(NB_A_WORDS));
    assign src_w_ready = w_skid_rdy && w_allow;
    assign src_a_ready = a_skid_rdy && a_allow;

    stream_skid_buffer #(.WIDTH(MEM_BW)) u_w_skid (
        .clk       (clk),
        .srst      (srst_in),
        .in_data   (src_w_data),
        .in_valid  (src_w_valid && w_allow),
        .in_ready  (w_skid_rdy),
        .out_data  (weights_input),
        .out_valid (weights_valid),
        .out_ready (weights_ready)
    );

    stream_skid_buffer #(.WIDTH(MEM_BW)) u_a_skid (
        .clk       (clk),
        .srst      (srst_in),
        .in_data   (src_a_data),
        .in_valid  (src_a_valid && a_allow),
        .in_ready  (a_skid_rdy),
        .out_data  (activations_input),
        .out_valid (activations_valid),
        .out_ready (activations_ready)
    );

    // Layer sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (cmd_go) state_d = ST_START;
            ST_START:     state_d = ST_WAIT_RUN;
            ST_WAIT_RUN:  if (running) state_d = ST_STREAM;
            ST_STREAM:    if ((w_cnt_q == cnt_t'(NB_W_WORDS)) &&
                              (a_cnt_q == cnt_t'(NB_A_WORDS))) state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (!running) state_d = ST_DRAIN;
            ST_DRAIN:     if ((o_cnt_q == cnt_t'(NB_O_WORDS)) &&
                              (fill_q == '0)) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Word counters: enqueued (host side) and transferred (chip side).
    always_comb begin
        w_cnt_d = w_cnt_q;
        a_cnt_d = a_cnt_q;
        w_enq_d = w_enq_q;
        a_enq_d = a_enq_q;
        if (go_accept) begin
            w_cnt_d = '0;
            a_cnt_d = '0;
            w_enq_d = '0;
            a_enq_d = '0;
        end else begin
            if (weights_valid && weights_ready)         w_cnt_d = w_cnt_q + cnt_t'(1);
            if (activations_valid && activations_ready) a_cnt_d = a_cnt_q + cnt_t'(1);
            if (src_w_valid && src_w_ready)             w_enq_d = w_enq_q + cnt_t'(1);
            if (src_a_valid && src_a_ready)             a_enq_d = a_enq_q + cnt_t'(1);
        end
    end

    // Output capture FIFO; a full buffer still accepts when it is popped the same cycle.
    assign full   = (fill_q == FILL_W'(OBUF_DEPTH));
    assign pop    = snk_valid_q && snk_ready;
    assign wr_req = in_capture(state_q) && output_valid;
    assign push   = wr_req && (!full || pop);

    always_comb begin
        obuf_d   = obuf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        o_cnt_d  = o_cnt_q;
        err_d    = err_q;
        if (push) begin
            obuf_d[wr_ptr_q] = out;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        fill_d = fill_q + FILL_W'(push) - FILL_W'(pop);
        if (go_accept) begin
            o_cnt_d = '0;
        end else if (wr_req) begin
            o_cnt_d = o_cnt_q + cnt_t'(1);
        end
        if (wr_req && !push) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        obuf_q <= obuf_d;
    end

    always_ff @(posedge clk) begin
        if (srst_in) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            w_cnt_q     <= '0;
            a_cnt_q     <= '0;
            o_cnt_q     <= '0;
            w_enq_q     <= '0;
            a_enq_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            snk_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            start_q     <= (state_d == ST_START);
            err_q       <= err_d;
            w_cnt_q     <= w_cnt_d;
            a_cnt_q     <= a_cnt_d;
            o_cnt_q     <= o_cnt_d;
            w_enq_q     <= w_enq_d;
            a_enq_q     <= a_enq_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            snk_valid_q <= (fill_d != '0);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign start        = start_q;
    assign err_overflow = err_q;
    assign snk_valid    = snk_valid_q;
    assign snk_data     = obuf_q[rd_ptr_q];

`ifdef DRV_PERF_CNT_EN
    // Cycles with the chip running during a layer; saturating, held after done.
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (go_accept) begin
            perf_d = '0;
        end else if (running && (state_q != ST_IDLE) && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_in) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
